// File: rtl/imm_encode_pkg.sv
// Shared RV32IM immediate-format definitions for the encode unit and the decode-side extractor.
// Holds opcodes, the format enum, error bit indices and the immediate scatter function.
package imm_encode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R,
        FMT_BAD
    } fmt_t;

    localparam int unsigned ERR_RANGE  = 0;
    localparam int unsigned ERR_ALIGN  = 1;
    localparam int unsigned ERR_OPCODE = 2;
    localparam int unsigned ERR_W      = 3;

    // Template bits outside the immediate field survive; out-of-range values are truncated.
    function automatic logic [31:0] pack_imm(fmt_t fmt, logic [31:0] tmpl, logic [31:0] imm);
        logic [31:0] instr;
        instr = tmpl;
        case (fmt)
            FMT_I:   instr = {imm[11:0], tmpl[19:0]};
            FMT_S:   instr = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
            FMT_B:   instr = {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]};
            FMT_U:   instr = {imm[31:12], tmpl[11:0]};
            FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
            default: instr = tmpl;
        endcase
        return instr;
    endfunction

endpackage

// File: rtl/imm_encode_unit_if.sv
// Request/result handshake bundle of imm_encode_unit.
// The slave modport is the unit's view; master is the requester/consumer side.
interface imm_encode_unit_if;

    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_TEMPLATE;
    logic [31:0] IN_IMM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_INSTR;
    logic [2:0]  OUT_ERR;

    modport slave (
        input  IN_VALID, IN_TEMPLATE, IN_IMM, OUT_READY,
        output IN_READY, OUT_VALID, OUT_INSTR, OUT_ERR
    );

    modport master (
        output IN_VALID, IN_TEMPLATE, IN_IMM, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_INSTR, OUT_ERR
    );

endinterface

// File: rtl/imm_fmt_check.sv
// Combinational opcode-to-format classification plus signed range and alignment checks.
module imm_fmt_check
    import imm_encode_pkg::*;
(
    input  logic [6:0]       opcode_i,
    input  logic [31:0]      imm_i,
    output fmt_t             fmt_o,
    output logic [ERR_W-1:0] err_o
);

    logic signed [31:0] simm;
    fmt_t               fmt;

    assign simm  = $signed(imm_i);
    assign fmt_o = fmt;

    always_comb begin
        fmt = FMT_BAD;
        unique case (opcode_i)
            OPC_LOAD, OPC_JALR, OPC_OP_IMM: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            OPC_OP:                         fmt = FMT_R;
            default:                        fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        err_o = '0;
        case (fmt)
            FMT_I, FMT_S: err_o[ERR_RANGE] = (simm > 2047) || (simm < -2048);
            FMT_B: begin
                err_o[ERR_RANGE] = (simm > 4094) || (simm < -4096);
                err_o[ERR_ALIGN] = imm_i[0];
            end
            FMT_J: begin
                err_o[ERR_RANGE] = (simm > 1048574) || (simm < -1048576);
                err_o[ERR_ALIGN] = imm_i[0];
            end
            FMT_U:   err_o[ERR_ALIGN] = |imm_i[11:0];
            FMT_BAD: err_o[ERR_OPCODE] = 1'b1;
            default: err_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_encode_unit.sv
// Two-stage immediate encoder: stage 1 classifies and checks, stage 2 scatters the immediate.
// Optional IMM_ERR_COUNT_EN adds a saturating count of erroneous results on ERR_COUNT.
module imm_encode_unit
    import imm_encode_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input logic           CLK,
    input logic           RESET,
    imm_encode_unit_if.slave bus
`ifdef IMM_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_COUNT
`endif
);

    logic             s1_valid_q, s1_valid_d;
    fmt_t             s1_fmt_q, s1_fmt_d;
    logic [31:0]      s1_tmpl_q, s1_tmpl_d;
    logic [31:0]      s1_imm_q, s1_imm_d;
    logic [ERR_W-1:0] s1_err_q, s1_err_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_instr_q, s2_instr_d;
    logic [ERR_W-1:0] s2_err_q, s2_err_d;

    fmt_t             chk_fmt;
    logic [ERR_W-1:0] chk_err;
    logic             s1_advance;
    logic             in_ready;

    imm_fmt_check u_fmt_check (
        .opcode_i (bus.IN_TEMPLATE[6:0]),
        .imm_i    (bus.IN_IMM),
        .fmt_o    (chk_fmt),
        .err_o    (chk_err)
    );

    assign s1_advance    = !s2_valid_q || bus.OUT_READY;
    assign in_ready      = !s1_valid_q || s1_advance;
    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = s2_valid_q;
    assign bus.OUT_INSTR = s2_instr_q;
    assign bus.OUT_ERR   = s2_err_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_fmt_d   = s1_fmt_q;
        s1_tmpl_d  = s1_tmpl_q;
        s1_imm_d   = s1_imm_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;

        if (in_ready) begin
            s1_valid_d = bus.IN_VALID;
            if (bus.IN_VALID) begin
                s1_fmt_d  = chk_fmt;
                s1_tmpl_d = bus.IN_TEMPLATE;
                s1_imm_d  = bus.IN_IMM;
                s1_err_d  = chk_err;
            end
        end

        // Stage 2 refills in the same cycle it drains, so a full pipe streams without bubbles.
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = pack_imm(s1_fmt_q, s1_tmpl_q, s1_imm_q);
                s2_err_d   = s1_err_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FMT_BAD;
            s1_tmpl_q  <= '0;
            s1_imm_q   <= '0;
            s1_err_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_tmpl_q  <= s1_tmpl_d;
            s1_imm_q   <= s1_imm_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
        end
    end

`ifdef IMM_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && bus.OUT_READY && (|s2_err_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_COUNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encode_unit.sv
// Directed, table-driven bench for imm_encode_unit plus stall, drain and mid-stream reset sequences.
module tb_imm_encode_unit;

    typedef struct {
        logic [31:0] tmpl;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [2:0]  exp_err;
    } vec_t;

    localparam int NVEC = 18;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic [15:0] err_count;

    vec_t vecs [NVEC];
    int   n_vec = 0;
    int   n_miss = 0;
    int   exp_cnt = 0;

    imm_encode_unit_if bus ();

    imm_encode_unit #(.ERR_CNT_W(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
`ifdef IMM_ERR_COUNT_EN
        ,
        .ERR_COUNT (err_count)
`endif
    );

`ifndef IMM_ERR_COUNT_EN
    assign err_count = '0;
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_count(input string name);
`ifdef IMM_ERR_COUNT_EN
        chk(name, {16'h0, err_count}, exp_cnt);
`endif
    endtask

    task automatic run_vec(input int idx);
        int cyc;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge CLK);
        bus.IN_VALID    = 1'b1;
        bus.IN_TEMPLATE = vecs[idx].tmpl;
        bus.IN_IMM      = vecs[idx].imm;
        cyc = 0;
        while (!bus.IN_READY && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        cyc = 0;
        while (!bus.OUT_VALID && cyc < 10) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (!bus.OUT_VALID) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: no OUT_VALID within 10 cycles, required 1", nm);
        end else begin
            chk({nm, "_latency"}, cyc, 1);
            chk({nm, "_instr"}, bus.OUT_INSTR, vecs[idx].exp_instr);
            chk({nm, "_err"}, {29'h0, bus.OUT_ERR}, {29'h0, vecs[idx].exp_err});
            if (vecs[idx].exp_err != 3'b000) exp_cnt++;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, cyc;
        logic rdy, drv, ov;
        logic [31:0] oi;
        logic [2:0] oe;

        vecs[0]  = '{32'h00000093, 32'hFFFFFFFF, 32'hFFF00093, 3'b000};
        vecs[1]  = '{32'h00000093, 32'h00000800, 32'h80000093, 3'b001};
        vecs[2]  = '{32'h0020A023, 32'h000007FC, 32'h7E20AE23, 3'b000};
        vecs[3]  = '{32'h00000063, 32'hFFFFFFF8, 32'hFE000CE3, 3'b000};
        vecs[4]  = '{32'h00000063, 32'h00000003, 32'h00000163, 3'b010};
        vecs[5]  = '{32'h000000EF, 32'h00000800, 32'h001000EF, 3'b000};
        vecs[6]  = '{32'h000002B7, 32'h12345000, 32'h123452B7, 3'b000};
        vecs[7]  = '{32'h000002B7, 32'h12345001, 32'h123452B7, 3'b010};
        vecs[8]  = '{32'hDEADBEFF, 32'h00000123, 32'hDEADBEFF, 3'b100};
        vecs[9]  = '{32'hABC00093, 32'h00000005, 32'h00500093, 3'b000};
        vecs[10] = '{32'h00000093, 32'hFFFFF800, 32'h80000093, 3'b000};
        vecs[11] = '{32'h00000063, 32'h00001000, 32'h80000063, 3'b001};
        vecs[12] = '{32'h00000063, 32'h00000FFE, 32'h7E000FE3, 3'b000};
        vecs[13] = '{32'h000000EF, 32'hFFFFFFFE, 32'hFFFFF0EF, 3'b000};
        vecs[14] = '{32'h000000EF, 32'h00100000, 32'h800000EF, 3'b001};
        vecs[15] = '{32'h00208033, 32'hFFFFFFFF, 32'h00208033, 3'b000};
        vecs[16] = '{32'h00000023, 32'hFFFFF7FF, 32'h7E000FA3, 3'b001};
        vecs[17] = '{32'h00000017, 32'hFFFFF000, 32'hFFFFF017, 3'b000};

        bus.IN_VALID    = 1'b0;
        bus.IN_TEMPLATE = '0;
        bus.IN_IMM      = '0;
        bus.OUT_READY   = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'h0, bus.OUT_VALID}, 0);
        chk("rst_out_instr", bus.OUT_INSTR, 0);
        chk("rst_out_err", {29'h0, bus.OUT_ERR}, 0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_in_ready", {31'h0, bus.IN_READY}, 1);
        chk_count("rst_err_count");

        for (int i = 0; i < NVEC; i++) run_vec(i);
        chk_count("table_err_count");

        // Stall: 4 requests, consumer blocked for 5 cycles
        bus.OUT_READY = 1'b0;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            drv = (sent < 4);
            bus.IN_VALID = drv;
            if (drv) begin
                bus.IN_TEMPLATE = vecs[sent].tmpl;
                bus.IN_IMM      = vecs[sent].imm;
            end
            #1;
            rdy = bus.IN_READY;
            if (c >= 2) begin
                chk($sformatf("stall_valid_c%0d", c), {31'h0, bus.OUT_VALID}, 1);
                chk($sformatf("stall_instr_c%0d", c), bus.OUT_INSTR, vecs[0].exp_instr);
            end
            @(posedge CLK);
            if (rdy && drv) sent++;
        end
        chk("stall_accepts", sent, 2);
        @(negedge CLK);
        #1;
        chk("stall_in_ready", {31'h0, bus.IN_READY}, 0);

        // Release: outputs must come back in order, one per cycle
        bus.OUT_READY = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 30) begin
            if (cyc != 0) @(negedge CLK);
            drv = (sent < 4);
            bus.IN_VALID = drv;
            if (drv) begin
                bus.IN_TEMPLATE = vecs[sent].tmpl;
                bus.IN_IMM      = vecs[sent].imm;
            end
            #1;
            rdy = bus.IN_READY;
            ov  = bus.OUT_VALID;
            oi  = bus.OUT_INSTR;
            oe  = bus.OUT_ERR;
            @(posedge CLK);
            if (rdy && drv) sent++;
            if (ov) begin
                chk($sformatf("drain_instr%0d", got), oi, vecs[got].exp_instr);
                chk($sformatf("drain_err%0d", got), {29'h0, oe}, {29'h0, vecs[got].exp_err});
                if (vecs[got].exp_err != 3'b000) exp_cnt++;
                got++;
            end
            cyc++;
        end
        bus.IN_VALID = 1'b0;
        chk("drain_count", got, 4);
        chk("drain_cycles", cyc, 4);
        #1;
        chk_count("drain_err_count");

        // Reset in the middle of a stalled stream
        bus.OUT_READY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            bus.IN_VALID    = 1'b1;
            bus.IN_TEMPLATE = vecs[8 + c].tmpl;
            bus.IN_IMM      = vecs[8 + c].imm;
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        #1;
        chk("pre_rst_valid", {31'h0, bus.OUT_VALID}, 1);
        RESET = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, bus.OUT_VALID}, 0);
        chk("midrst_out_instr", bus.OUT_INSTR, 0);
        chk("midrst_out_err", {29'h0, bus.OUT_ERR}, 0);
        exp_cnt = 0;
        chk_count("midrst_err_count");
        @(negedge CLK);
        RESET = 1'b1;
        bus.OUT_READY = 1'b1;
        #1;
        chk("midrst_in_ready", {31'h0, bus.IN_READY}, 1);
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (bus.OUT_VALID) got++;
        end
        chk("post_rst_emitted", got, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
